// File: rtl/branch_predictor.sv
// Two-bit saturating-counter branch predictor with bimodal or gshare indexing,
// speculative global history with mispredict repair, and a power-up sweep
// that writes every counter to INIT before predictions are allowed.
module branch_predictor #(
  parameter int         TABLE_BITS = 10,
  parameter int         HIST_BITS  = 8,
  parameter int         MODE       = 1,
  parameter logic [1:0] INIT       = 2'b01
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  p_valid,
  input  logic [31:0]           p_pc,
  output logic                  p_taken,
  output logic [TABLE_BITS-1:0] p_index,
  output logic [HIST_BITS-1:0]  p_ghr,
  input  logic                  u_valid,
  input  logic [TABLE_BITS-1:0] u_index,
  input  logic                  u_taken,
  input  logic                  u_mispredict,
  input  logic [HIST_BITS-1:0]  u_ghr,
  output logic                  ready,
  output logic [31:0]           n_pred,
  output logic [31:0]           n_mispred
);

  localparam int                    ENTRIES    = 1 << TABLE_BITS;
  localparam logic [TABLE_BITS-1:0] SWEEP_LAST = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [TABLE_BITS-1:0] sweep_q, sweep_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [31:0]           n_pred_q, n_pred_d;
  logic [31:0]           n_mispred_q, n_mispred_d;
  logic [1:0]            tbl_q [ENTRIES];

  logic [TABLE_BITS-1:0] pc_idx;
  logic [TABLE_BITS-1:0] ghr_ext;
  logic                  pred_acc;
  logic                  upd_acc;
  logic                  repair;
  logic                  unused_bits;

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
    if (up) begin
      return (c == 2'b11) ? c : c + 2'b01;
    end
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Shift a new outcome into the LSB of a history vector; works for HIST_BITS=1.
  function automatic logic [HIST_BITS-1:0] hist_push(input logic [HIST_BITS-1:0] h,
                                                     input logic b);
    logic [HIST_BITS-1:0] r;
    r[0] = b;
    for (int i = 1; i < HIST_BITS; i++) begin
      r[i] = h[i-1];
    end
    return r;
  endfunction

  // PC bits outside the index field and the oldest returned history bit are not needed.
  assign unused_bits = ^{p_pc[31:TABLE_BITS+2], p_pc[1:0], u_ghr[HIST_BITS-1]};

  // FSM next state: sweep one entry per cycle, then run forever until reset.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready   = 1'b0;
    case (state_q)
      S_INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == SWEEP_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_d = S_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // Prediction index and combinational direction lookup (read-before-write).
  always_comb begin
    pc_idx                   = p_pc[TABLE_BITS+1:2];
    ghr_ext                  = '0;
    ghr_ext[HIST_BITS-1:0]   = ghr_q;
    p_index                  = (MODE == 1) ? (pc_idx ^ ghr_ext) : pc_idx;
    p_taken                  = ready & tbl_q[p_index][1];
    p_ghr                    = ghr_q;
  end

  assign pred_acc = p_valid & ready;
  assign upd_acc  = u_valid & ready;
  assign repair   = upd_acc & u_mispredict;

  // History and statistics next state; repair wins over a speculative shift.
  always_comb begin
    ghr_d       = ghr_q;
    n_pred_d    = n_pred_q;
    n_mispred_d = n_mispred_q;
    if (repair) begin
      ghr_d = hist_push(u_ghr, u_taken);
    end else if (pred_acc) begin
      ghr_d = hist_push(ghr_q, p_taken);
    end
    if (pred_acc) begin
      n_pred_d = n_pred_q + 32'd1;
    end
    if (repair) begin
      n_mispred_d = n_mispred_q + 32'd1;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_INIT;
      sweep_q     <= '0;
      ghr_q       <= '0;
      n_pred_q    <= '0;
      n_mispred_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      ghr_q       <= ghr_d;
      n_pred_q    <= n_pred_d;
      n_mispred_q <= n_mispred_d;
    end
  end

  // Counter table: sweep writes INIT, resolved branches train; reset alone writes nothing.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (state_q == S_INIT) begin
        tbl_q[sweep_q] <= INIT;
      end else if (upd_acc) begin
        tbl_q[u_index] <= sat_update(tbl_q[u_index], u_taken);
      end
    end
  end

  assign n_pred    = n_pred_q;
  assign n_mispred = n_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal and a gshare instance share every input so the
// same training sequence can be observed through both indexing schemes.
module tb_branch_predictor;

  localparam int TB = 4;
  localparam int HB = 2;

  logic          clk;
  logic          resetn;
  logic          p_valid;
  logic [31:0]   p_pc;
  logic          u_valid;
  logic [TB-1:0] u_index;
  logic          u_taken;
  logic          u_mispredict;
  logic [HB-1:0] u_ghr;

  logic          p_taken0, p_taken1;
  logic [TB-1:0] p_index0, p_index1;
  logic [HB-1:0] p_ghr0, p_ghr1;
  logic          ready0, ready1;
  logic [31:0]   n_pred0, n_pred1, n_mispred0, n_mispred1;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.TABLE_BITS(TB), .HIST_BITS(HB), .MODE(0), .INIT(2'b01)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_pc(p_pc), .p_taken(p_taken0), .p_index(p_index0), .p_ghr(p_ghr0),
    .u_valid(u_valid), .u_index(u_index), .u_taken(u_taken), .u_mispredict(u_mispredict),
    .u_ghr(u_ghr), .ready(ready0), .n_pred(n_pred0), .n_mispred(n_mispred0)
  );

  branch_predictor #(.TABLE_BITS(TB), .HIST_BITS(HB), .MODE(1), .INIT(2'b01)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .p_valid(p_valid), .p_pc(p_pc), .p_taken(p_taken1), .p_index(p_index1), .p_ghr(p_ghr1),
    .u_valid(u_valid), .u_index(u_index), .u_taken(u_taken), .u_mispredict(u_mispredict),
    .u_ghr(u_ghr), .ready(ready1), .n_pred(n_pred1), .n_mispred(n_mispred1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leaves time 2 units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    p_valid      = 1'b0;
    u_valid      = 1'b0;
    u_mispredict = 1'b0;
    u_taken      = 1'b0;
    u_index      = '0;
    u_ghr        = '0;
  endtask

  task automatic update(input logic [TB-1:0] idx, input logic tk);
    u_valid = 1'b1; u_index = idx; u_taken = tk; u_mispredict = 1'b0;
    tick();
    u_valid = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    p_pc   = 32'h0;
    idle();
    tick();
    tick();
    // Reset state
    chk("rst_ready", ready1, 1'b0);
    chk("rst_ptaken", p_taken1, 1'b0);
    chk("rst_npred", n_pred1, 32'd0);
    chk("rst_nmisp", n_mispred1, 32'd0);
    chk("rst_ghr", p_ghr1, 2'b00);

    // Release reset with activity that must be ignored during the sweep
    resetn = 1'b1;
    p_valid = 1'b1; u_valid = 1'b1; u_mispredict = 1'b1; u_taken = 1'b1;
    u_index = 4'd5; u_ghr = 2'b01; p_pc = 32'h14;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("sweep_ready_%0d", i), ready1, (i == 16));
      if (i < 16) chk($sformatf("sweep_ptaken_%0d", i), p_taken1, 1'b0);
    end
    idle();
    #1;
    chk("init_npred", n_pred1, 32'd0);
    chk("init_nmisp", n_mispred1, 32'd0);
    chk("init_ghr", p_ghr1, 2'b00);
    for (int k = 0; k < 16; k++) begin
      p_pc = 32'(k) << 2;
      #1;
      chk($sformatf("init_entry_%0d", k), p_taken0, 1'b0);
    end

    // Saturation at index 5 (pc 0x14, bimodal)
    p_pc = 32'h14;
    #1;
    chk("sat_index", p_index0, 4'd5);
    update(4'd5, 1'b1);
    update(4'd5, 1'b1);
    update(4'd5, 1'b1);
    chk("sat_up3", p_taken0, 1'b1);
    update(4'd5, 1'b0);
    chk("sat_dn1", p_taken0, 1'b1);
    update(4'd5, 1'b0);
    chk("sat_dn2", p_taken0, 1'b0);
    update(4'd5, 1'b0);
    update(4'd5, 1'b0);
    update(4'd5, 1'b0);
    chk("sat_floor", p_taken0, 1'b0);
    update(4'd5, 1'b1);
    chk("sat_floor_up1", p_taken0, 1'b0);
    update(4'd5, 1'b1);
    chk("sat_floor_up2", p_taken0, 1'b1);

    // Gshare index: repair history to 11, then look up pc 0x14
    u_valid = 1'b1; u_mispredict = 1'b1; u_ghr = 2'b01; u_taken = 1'b1; u_index = 4'd0;
    tick();
    idle();
    p_pc = 32'h14;
    #1;
    chk("gs_ghr", p_ghr1, 2'b11);
    chk("gs_index", p_index1, 4'b0110);
    chk("gs_bimodal_index", p_index0, 4'd5);
    chk("gs_nmisp", n_mispred1, 32'd1);

    // Repair priority: history 01, simultaneous prediction and repair
    u_valid = 1'b1; u_mispredict = 1'b1; u_ghr = 2'b00; u_taken = 1'b1; u_index = 4'd15;
    tick();
    idle();
    #1;
    chk("rp_pre_ghr", p_ghr1, 2'b01);
    p_pc = 32'h10;
    p_valid = 1'b1;
    u_valid = 1'b1; u_mispredict = 1'b1; u_ghr = 2'b10; u_taken = 1'b0; u_index = 4'd15;
    #1;
    chk("rp_ptaken", p_taken1, 1'b1);
    tick();
    idle();
    #1;
    chk("rp_ghr", p_ghr1, 2'b00);
    chk("rp_npred", n_pred1, 32'd1);
    chk("rp_nmisp", n_mispred1, 32'd3);

    // Speculative shift without repair
    p_pc = 32'h14;
    p_valid = 1'b1;
    #1;
    chk("sh_ptaken", p_taken1, 1'b1);
    tick();
    idle();
    #1;
    chk("sh_ghr", p_ghr1, 2'b01);
    chk("sh_npred", n_pred1, 32'd2);

    // Read-before-write at index 2 holding 01
    p_pc = 32'h08;
    u_valid = 1'b1; u_index = 4'd2; u_taken = 1'b1; u_mispredict = 1'b0;
    #1;
    chk("rbw_same", p_taken0, 1'b0);
    tick();
    idle();
    #1;
    chk("rbw_next", p_taken0, 1'b1);

    // Reset from RUN, then again mid-sweep at entry 9
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_ready", ready1, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("resweep_ready_%0d", i), ready1, (i == 16));
    end
    chk("resweep_npred", n_pred1, 32'd0);
    chk("resweep_nmisp", n_mispred1, 32'd0);
    chk("resweep_ghr", p_ghr1, 2'b00);
    p_pc = 32'h14;
    #1;
    chk("resweep_e5", p_taken0, 1'b0);
    p_pc = 32'h08;
    #1;
    chk("resweep_e2", p_taken0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter TABLE_BITS, default 10, log2 of the number of 2-bit counter entries (range 2..16).
REQ-002 Parameter HIST_BITS, default 8, global history length (range 1..TABLE_BITS).
REQ-003 Parameter MODE, default 1, index mode: 0 = bimodal (PC only), 1 = gshare (PC xor history).
REQ-004 Parameter INIT, default 2'b01, counter value written during the init sweep.
REQ-005 Port clk, input, 1, the single clock, rising edge.
REQ-006 Port resetn, input, 1, reset: synchronous, active-low.
REQ-007 Port p_valid, input, 1, decode stage holds a conditional branch needing a prediction.
REQ-008 Port p_pc, input, 32, PC of that branch.
REQ-009 Port p_taken, output, 1, predicted direction, combinational, same cycle.
REQ-010 Port p_index, output, TABLE_BITS, table index used for this prediction, to be carried down the pipe.
REQ-011 Port p_ghr, output, HIST_BITS, history snapshot before this prediction's shift.
REQ-012 Port u_valid, input, 1, execute stage resolves a conditional branch.
REQ-013 Port u_index, input, TABLE_BITS, index returned from p_index.
REQ-014 Port u_taken, input, 1, actual direction.
REQ-015 Port u_mispredict, input, 1, actual direction differs from the prediction.
REQ-016 Port u_ghr, input, HIST_BITS, snapshot returned from p_ghr.
REQ-017 Port ready, output, 1, table initialised; low during the init sweep.
REQ-018 Port n_pred, output, 32, count of accepted predictions.
REQ-019 Port n_mispred, output, 32, count of accepted mispredict updates.

Function
REQ-020 Index: MODE 0 gives p_pc[TABLE_BITS+1:2]; MODE 1 gives p_pc[TABLE_BITS+1:2] XOR the zero-extended GHR.
REQ-021 p_taken equals bit 1 of the indexed counter when ready=1, and is forced to 0 when ready=0.
REQ-022 Table read is asynchronous and read-before-write: a same-cycle update to the same index is not visible to p_taken until the next cycle.
REQ-023 When u_valid=1 and ready=1, the counter at u_index saturates: +1 if u_taken (capped at 11), -1 otherwise (floored at 00).
REQ-024 Speculative history: when p_valid=1, ready=1 and no repair occurs in that cycle, GHR <= {GHR[HIST_BITS-2:0], p_taken}; for HIST_BITS=1, GHR <= p_taken.
REQ-025 Repair: when u_valid=1, u_mispredict=1 and ready=1, GHR <= {u_ghr[HIST_BITS-2:0], u_taken}; repair has priority over a same-cycle speculative shift.
REQ-026 In MODE 0 the GHR is still maintained but does not affect the index.
REQ-027 n_pred increments on each p_valid&ready cycle; n_mispred increments on each u_valid&u_mispredict&ready cycle; both wrap modulo 2^32.
REQ-028 Inputs p_valid and u_valid may both be active in one cycle; both take effect per REQ-023 to REQ-027.
REQ-029 FSM states: INIT (sweep counter writes INIT to entry k, k=0..2^TABLE_BITS-1, one entry per cycle) and RUN.
REQ-030 INIT exits to RUN after writing the last entry; ready=1 only in RUN, from the cycle after the last write.
REQ-031 While in INIT, all p_valid and u_valid activity is ignored (no table, GHR or counter change).

Reset
REQ-032 resetn=0 at a rising edge sets state=INIT, sweep counter=0, GHR=0, n_pred=0, n_mispred=0.
REQ-033 Out of reset, ready=0 and p_taken=0.
REQ-034 Reset asserted mid-sweep or in RUN restarts the sweep from entry 0.
REQ-035 Table contents are not cleared by reset itself, only by the sweep.
REQ-036 ready first rises exactly 2^TABLE_BITS cycles after the first edge sampled with resetn=1.

Verification (bench: TABLE_BITS=4, HIST_BITS=2)
REQ-037 Init timing: release reset -> ready=0 for 16 cycles, then 1; every entry reads INIT (p_taken=0).
REQ-038 Saturation: 3 taken updates at index 5 -> counter 11, p_taken=1 at pc 0x14 (MODE 0); 4 not-taken updates -> 00; a further not-taken update stays at 00.
REQ-039 Gshare index: MODE 1, GHR=2'b11, p_pc=0x14 -> p_index=4'b0110; p_ghr=2'b11.
REQ-040 Repair priority: GHR=2'b01, same-cycle p_valid (p_taken=1) and u_mispredict with u_ghr=2'b10, u_taken=0 -> next GHR=2'b00; n_pred +1, n_mispred +1.
REQ-041 Read-before-write: same-cycle update and predict at an index holding 01 with u_taken=1 -> p_taken=0 this cycle, 1 next cycle.
REQ-042 Mid-sweep reset: resetn=0 at sweep entry 9 -> sweep restarts at 0; ready rises 16 cycles after release; counters read 0.
